// File: rtl/wshb_arbiter.sv
// wshb_arbiter: round-robin, cyc-granular arbiter sharing one Wishbone slave between two masters
module wshb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  output logic [1:0]              gnt
);
  localparam int BW = 3 + ADDR_WIDTH + 8 * DATA_BYTES + DATA_BYTES + 5;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic last_gnt;
  logic [BW-1:0] m0_bus, m1_bus;
  always_comb begin
    state_nx = state == GNT0 && m0_cyc ? GNT0 :
               state == GNT1 && m1_cyc ? GNT1 :
               m0_cyc && m1_cyc ? (last_gnt ? GNT0 : GNT1) :
               m0_cyc ? GNT0 :
               m1_cyc ? GNT1 : IDLE;
    m0_bus = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte};
    m1_bus = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte};
    {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte} =
      state == GNT0 ? m0_bus : state == GNT1 ? m1_bus : '0;
    m0_ack = s_ack && state == GNT0;
    m0_err = s_err && state == GNT0;
    m0_rty = s_rty && state == GNT0;
    m1_ack = s_ack && state == GNT1;
    m1_err = s_err && state == GNT1;
    m1_rty = s_rty && state == GNT1;
    m0_dat_sm = s_dat_sm;
    m1_dat_sm = s_dat_sm;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_gnt <= 1'b1;
      gnt <= 2'b00;
    end else begin
      state <= state_nx;
      gnt <= {state_nx == GNT1, state_nx == GNT0};
      last_gnt <= state_nx == GNT1 ? 1'b1 : state_nx == GNT0 ? 1'b0 : last_gnt;
    end
  end
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed bench with a transaction-level grant model checked every cycle
module tb_wshb_arbiter;
  localparam int AW = 32, DB = 4, DW = 8 * DB;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_dat_ms, m1_dat_ms, m0_dat_sm, m1_dat_sm, s_dat_ms, s_dat_sm;
  logic [DB-1:0] m0_sel, m1_sel, s_sel;
  logic [2:0] m0_cti, m1_cti, s_cti, term;
  logic [1:0] m0_bte, m1_bte, s_bte, gnt;
  logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  wshb_arbiter #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms),
    .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_dat_sm(m0_dat_sm),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms),
    .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_dat_sm(m1_dat_sm),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_dat_sm(s_dat_sm),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .gnt(gnt)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  bit chk_en = 0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  int own = -1;
  bit last = 1;
  always @(posedge clk) begin
    if (rst) begin
      own = -1;
      last = 1;
    end else if (!(own >= 0 && (own == 0 ? m0_cyc : m1_cyc))) begin
      own = (m0_cyc && m1_cyc) ? (last ? 0 : 1) : m0_cyc ? 0 : m1_cyc ? 1 : -1;
      if (own >= 0) last = (own == 1);
    end
  end
  always @(negedge clk) if (chk_en) begin : cmp
    logic [75:0] eb;
    logic [5:0] et;
    eb = own == 0 ? {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte} :
         own == 1 ? {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte} : '0;
    et = {s_ack && own == 0, s_err && own == 0, s_rty && own == 0,
          s_ack && own == 1, s_err && own == 1, s_rty && own == 1};
    chk("gnt", gnt, own < 0 ? 2'b00 : own == 0 ? 2'b01 : 2'b10);
    chk("s_bus", {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte}, eb);
    chk("term", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, et);
    chk("dat_sm", {m0_dat_sm, m1_dat_sm}, {s_dat_sm, s_dat_sm});
  end
  typedef struct {int own; int acks; int gap;} seg_t;
  seg_t seg_q[$];
  logic [63:0] wq[$];
  bit seg_valid = 0;
  int seg_own = 0, acks = 0, gap = 0;
  always @(negedge clk) if (chk_en) begin
    if (s_cyc && s_stb && s_we && s_ack && gnt == 2'b01) wq.push_back({s_adr, s_dat_ms});
    if (rst) begin
      seg_valid = 0;
      gap = 0;
      acks = 0;
    end else if (s_cyc) begin
      if (seg_valid && int'(gnt[1]) != seg_own) begin
        seg_q.push_back(seg_t'{seg_own, acks, gap});
        acks = 0;
      end
      if (!seg_valid) acks = 0;
      seg_valid = 1;
      seg_own = int'(gnt[1]);
      gap = 0;
      if (s_ack | s_err | s_rty) acks++;
    end else gap++;
  end
  bit act[2], we[2], slv_en, fix_en;
  int left[2], beat[2], rs[2], lat, cnt;
  logic [31:0] adr[2], base[2], fix_dat;
  task automatic drive;
    m0_cyc = act[0]; m0_stb = act[0]; m0_we = we[0]; m0_adr = adr[0];
    m0_dat_ms = we[0] ? (beat[0][0] ? 32'h0 : 32'h00FF_FFFF) : {16'h5A5A, beat[0][15:0]};
    m0_sel = 4'hF; m0_cti = left[0] == 1 ? 3'b111 : 3'b010; m0_bte = 2'b00;
    m1_cyc = act[1]; m1_stb = act[1]; m1_we = we[1]; m1_adr = adr[1];
    m1_dat_ms = {16'hA5A5, beat[1][15:0]};
    m1_sel = 4'h3; m1_cti = 3'b000; m1_bte = 2'b01;
  endtask
  task automatic start(input int i, input int n, input logic [31:0] b, input bit w);
    act[i] = 1; left[i] = n; beat[i] = 0; base[i] = b; adr[i] = b; we[i] = w;
    drive();
  endtask
  task automatic tick;
    logic [1:0] t;
    logic sc;
    @(negedge clk);
    t = {m1_ack | m1_err | m1_rty, m0_ack | m0_err | m0_rty};
    sc = s_cyc & s_stb;
    @(posedge clk);
    #1;
    if (slv_en) begin
      if (s_ack | s_err | s_rty) begin
        {s_ack, s_err, s_rty} = 3'b000;
        cnt = 0;
      end else if (sc) begin
        cnt++;
        if (cnt >= lat) {s_ack, s_err, s_rty} = term;
      end else cnt = 0;
      s_dat_sm = fix_en ? fix_dat : $urandom;
    end
    for (int i = 0; i < 2; i++)
      if (act[i] && t[i]) begin
        left[i]--; beat[i]++; adr[i] += 4;
        act[i] = left[i] > 0;
      end else if (!act[i] && rs[i] > 0) begin
        rs[i]--;
        start(i, 64, base[i], we[i]);
      end
    drive();
  endtask
  task automatic settle(input string n);
    int k = 0;
    while ((act[0] || act[1] || rs[0] > 0 || rs[1] > 0) && k < 3000) begin
      tick();
      k++;
    end
    chk({n, " done in budget"}, k < 3000, 1'b1);
    repeat (3) tick();
  endtask
  initial begin
    int n0, n1, k, bad;
    bit m1_up;
    slv_en = 1; lat = 1; term = 3'b100; cnt = 0; fix_en = 0; fix_dat = 0;
    {s_ack, s_err, s_rty} = 3'b000; s_dat_sm = 0;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; we[i] = 0; left[i] = 0; beat[i] = 0; rs[i] = 0; adr[i] = 0; base[i] = 0;
    end
    start(0, 1000, 32'h1000, 0);
    start(1, 1000, 32'h8000, 0);
    tick(); chk_en = 1; tick(); #2;
    chk("rst gnt", gnt, 2'b00);
    chk("rst s_cyc", s_cyc, 1'b0);
    chk("rst acks", {m0_ack, m1_ack}, 2'b00);
    rst = 0;
    tick(); #2;
    chk("rst release gnt", gnt, 2'b01);
    act[0] = 0; act[1] = 0; drive();
    settle("reset");
    lat = 3; fix_en = 1; fix_dat = 32'hDEAD_BEEF;
    start(1, 1, 32'h100, 0); #2;
    chk("single gnt idle", gnt, 2'b00);
    tick(); #2;
    chk("single gnt", gnt, 2'b10);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); #2;
      n0 += int'(m0_ack);
      if (m1_ack) begin
        n1++;
        chk("single dat", m1_dat_sm, 32'hDEAD_BEEF);
      end
    end
    chk("single m1 acks", n1, 1);
    chk("single m0 acks", n0, 0);
    fix_en = 0; lat = 1;
    settle("single");
    seg_q.delete(); seg_valid = 0;
    rs[0] = 1; rs[1] = 1;
    start(0, 64, 32'h1000, 0);
    start(1, 64, 32'h8000, 0);
    settle("rr");
    chk("rr segments", seg_q.size(), 3);
    for (int i = 0; i < seg_q.size(); i++) begin
      chk("rr owner", seg_q[i].own, i % 2);
      chk("rr acks", seg_q[i].acks, 64);
      chk("rr gap", seg_q[i].gap, 1);
    end
    seg_q.delete(); seg_valid = 0; wq.delete();
    start(0, 64, 32'h2000, 1);
    k = 0; bad = 0; m1_up = 0;
    while (act[0] && k < 1000) begin
      tick(); #2;
      if (m0_cyc && gnt[1]) bad++;
      if (left[0] == 54 && !m1_up) begin
        m1_up = 1;
        start(1, 5, 32'h3000, 0);
      end
      k++;
    end
    chk("hold m0 in budget", k < 1000, 1'b1);
    chk("hold m1 raised", m1_up, 1'b1);
    chk("hold no early m1 grant", bad, 0);
    settle("hold");
    chk("hold segments", seg_q.size(), 1);
    if (seg_q.size() > 0) begin
      chk("hold owner", seg_q[0].own, 0);
      chk("hold acks", seg_q[0].acks, 64);
      chk("hold gap", seg_q[0].gap, 1);
    end
    chk("hold writes", wq.size(), 64);
    for (int i = 0; i < wq.size(); i++) begin
      chk("hold adr", wq[i][63:32], 32'h2000 + 4 * i);
      chk("hold dat", wq[i][31:0], (i % 2) ? 32'h0 : 32'h00FF_FFFF);
    end
    start(1, 40, 32'h4000, 0);
    k = 0;
    while (left[1] > 20 && k < 500) begin
      tick();
      k++;
    end
    chk("midrst beat 20 reached", left[1], 20);
    rst = 1;
    start(0, 5, 32'h5000, 0);
    tick(); #2;
    chk("midrst s_cyc", s_cyc, 1'b0);
    chk("midrst gnt", gnt, 2'b00);
    chk("midrst m1 term", {m1_ack, m1_err, m1_rty}, 3'b000);
    rst = 0;
    tick(); #2;
    chk("midrst regrant", gnt, 2'b01);
    act[0] = 0; act[1] = 0; drive();
    settle("midrst");
    term = 3'b010;
    start(0, 1, 32'h6000, 0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); #2;
      n0 += int'(m0_err);
      n1 += int'(m1_err);
    end
    chk("err m0", n0, 1);
    chk("err m1", n1, 0);
    term = 3'b001;
    start(1, 1, 32'h7000, 0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); #2;
      n0 += int'(m0_rty);
      n1 += int'(m1_rty);
    end
    chk("rty m1", n1, 1);
    chk("rty m0", n0, 0);
    term = 3'b100;
    settle("termination");
    slv_en = 0;
    {s_ack, s_err, s_rty} = 3'b111; #2;
    chk("stray term", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, 6'b0);
    tick(); tick(); #2;
    chk("stray gnt", gnt, 2'b00);
    chk("stray s_cyc", s_cyc, 1'b0);
    {s_ack, s_err, s_rty} = 3'b000;
    slv_en = 1;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single SDRAM Wishbone slave port.
- Master 0 is the frame-buffer writer, such as the test-pattern generator. Master 1 is the display-side frame-buffer reader.
- Grants are round-robin at transaction (cyc) granularity. A grant is held until the owning master drops cyc. Masters bound their own transactions; the pattern writer releases every 64 pixels.
- Sits between the two masters and the SDRAM controller's Wishbone slave.

Parameters:
ADDR_WIDTH, 32, width of adr on all ports
DATA_BYTES, 4, data width in bytes; dat width = 8*DATA_BYTES, sel width = DATA_BYTES

Ports:
clk  input  1  system clock; all ports synchronous to it
rst  input  1  synchronous, active-high reset
m0_cyc, m0_stb, m0_we  input  1 each  master 0 Wishbone controls
m0_adr  input  ADDR_WIDTH  master 0 address
m0_dat_ms  input  8*DATA_BYTES  master 0 write data
m0_sel  input  DATA_BYTES  master 0 byte select
m0_cti  input  3  master 0 cycle type
m0_bte  input  2  master 0 burst type
m0_dat_sm  output  8*DATA_BYTES  read data to master 0
m0_ack, m0_err, m0_rty  output  1 each  terminations to master 0
m1_*  same set as m0_*  master 1 (display reader)
s_cyc, s_stb, s_we  output  1 each  controls to SDRAM slave
s_adr  output  ADDR_WIDTH  address to slave
s_dat_ms  output  8*DATA_BYTES  write data to slave
s_sel  output  DATA_BYTES  byte select to slave
s_cti  output  3  cycle type to slave
s_bte  output  2  burst type to slave
s_dat_sm  input  8*DATA_BYTES  read data from slave
s_ack, s_err, s_rty  input  1 each  terminations from slave
gnt  output  2  one-hot current grant, bit0 = master 0; 2'b00 when idle

Behaviour:
- FSM states: IDLE, GNT0, GNT1, held in a register. last_gnt is a 1-bit register holding the index of the most recently granted master.
- Reset, taking effect at the next clk edge with rst=1: state=IDLE, last_gnt=1 (master 0 wins the first contention), gnt=00.
  - All s_* outputs are driven 0 while in IDLE.
  - m0_ack/err/rty and m1_ack/err/rty are 0.
- Reset during an active transaction: the slave sees s_cyc=0 from the first cycle after the reset edge. The in-flight transfer is abandoned and no termination is forwarded.
- IDLE transitions:
  - Only m0_cyc=1: go to GNT0.
  - Only m1_cyc=1: go to GNT1.
  - Both m0_cyc=1 and m1_cyc=1: go to the master with index != last_gnt.
  - Neither: stay in IDLE.
- On entry to GNTx, last_gnt is set to x.
- GNTx transitions:
  - Stay while mx_cyc=1.
  - When mx_cyc=0: go to GNTy if the other master's my_cyc=1, otherwise go to IDLE.
- Grant latency:
  - A master raising cyc in IDLE is granted on the next cycle; its cyc/stb reach the slave one cycle after being raised.
  - The requesting master simply holds cyc/stb until it receives ack; no extra handshake is needed.
- Bus gap: in the cycle where the owner drops cyc, the state is still GNTx and s_cyc = mx_cyc = 0. This guarantees at least one s_cyc=0 cycle between two different owners.
- Slave-side mux (combinational from state):
  - In GNTx, every s_* output equals the corresponding mx_* input.
  - In IDLE, all s_* outputs are 0.
- Master-side returns:
  - mx_ack = s_ack & (state==GNTx); err and rty are routed the same way.
  - A non-granted master never sees a termination.
  - s_dat_sm is broadcast to both m0_dat_sm and m1_dat_sm without gating.
- gnt: 01 in GNT0, 10 in GNT1, 00 in IDLE. Never 11.
- No combinational path from any mx_cyc to the state register other than through the FSM next-state logic. State is updated only on the clk edge.
- A master dropping cyc while its stb is pending is legal: the arbiter releases it and discards any later s_ack for it.

Test Plan:
- Reset: rst=1 for 2 cycles with both cyc=1 -> gnt=00, s_cyc=0, m0_ack=m1_ack=0. Release rst -> gnt=01 one cycle later.
- Single master: m1 raises cyc/stb, we=0, adr=0x100; slave acks after 3 cycles with dat_sm=0xDEADBEEF -> gnt=10 after 1 cycle, m1_ack pulses once with m1_dat_sm=0xDEADBEEF, m0_ack stays 0.
- Round-robin: both masters hold cyc continuously, each dropping cyc after 64 acks -> grants alternate 0,1,0,1. Each grant carries exactly 64 acks. Exactly one s_cyc=0 cycle occurs between consecutive grants.
- Hold: m0 in a 64-beat write (pattern data 0x00FFFFFF/0x0) while m1 raises cyc at beat 10 -> m1 is not granted until m0_cyc falls. All 64 m0 writes reach s_adr/s_dat_ms in order, unmodified.
- Reset mid-transfer: rst asserted at beat 20 of an m1 read -> next cycle s_cyc=0 and gnt=00. After release with both cyc=1, master 0 is granted.
- Stray ack: slave asserts s_ack while in IDLE -> m0_ack=m1_ack=0 and the state stays IDLE.
